// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: state encodings, default
// widths and requester indices.
package mem_port_arbiter_pkg;

  localparam int unsigned AddrWidthDef = 28;
  localparam int unsigned BlockSizeDef = 256;
  localparam int unsigned CntWidth     = 10;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrantI = 2'b01,
    StGrantD = 2'b10
  } arb_state_e;

  // Requester index as produced by rr_pick2 and held in last_grant.
  localparam logic ReqI = 1'b0;
  localparam logic ReqD = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin / fixed-priority selector. Index 1 wins ties in fixed
// mode; in round-robin mode the side that was not served last wins.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  input  logic fixed_i,
  output logic winner_o,
  output logic any_o
);

  always_comb begin
    any_o    = req0_i | req1_i;
    winner_o = 1'b0;
    if (req0_i && req1_i) begin
      winner_o = fixed_i ? 1'b1 : ~last_i;
    end else if (req1_i) begin
      winner_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single block-wide memory port between the I-cache and
// D-cache controllers; routes completion and read data to the granted side.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned BLOCK_SIZE = BlockSizeDef,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BLOCK_SIZE-1:0] i_wr,
  input  logic                  i_rw,
  input  logic                  i_valid,
  output logic [BLOCK_SIZE-1:0] i_rd,
  output logic                  i_ready,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [BLOCK_SIZE-1:0] d_wr,
  input  logic                  d_rw,
  input  logic                  d_valid,
  output logic [BLOCK_SIZE-1:0] d_rd,
  output logic                  d_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wr,
  output logic                  mem_rw,
  output logic                  mem_valid,
  input  logic [BLOCK_SIZE-1:0] mem_rd,
  input  logic                  mem_ready,
  output logic                  grant_i,
  output logic                  grant_d,
  output logic                  err_timeout
);

  localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(TIMEOUT);
  localparam logic                FixedMode  = (FIXED_PRIO != 0);

  arb_state_e          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic pick_winner;
  logic pick_any;

  rr_pick2 u_pick (
    .req0_i   (i_valid),
    .req1_i   (d_valid),
    .last_i   (last_grant_q),
    .fixed_i  (FixedMode),
    .winner_o (pick_winner),
    .any_o    (pick_any)
  );

  logic cur_valid;
  logic cur_side;

  always_comb begin
    cur_side  = (state_q == StGrantD) ? ReqD : ReqI;
    cur_valid = (state_q == StGrantD) ? d_valid : i_valid;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = (pick_winner == ReqD) ? StGrantD : StGrantI;
          cnt_d   = '0;
        end
      end
      StGrantI, StGrantD: begin
        // Completion takes precedence over an abandon in the same cycle.
        if (mem_ready || !cur_valid) begin
          state_d      = StIdle;
          last_grant_d = cur_side;
        end else if (cnt_q == TimeoutCnt) begin
          state_d      = StIdle;
          last_grant_d = cur_side;
          err_d        = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= ReqI;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wr    = '0;
    mem_rw    = 1'b0;
    mem_valid = 1'b0;
    i_ready   = 1'b0;
    i_rd      = '0;
    d_ready   = 1'b0;
    d_rd      = '0;
    grant_i   = (state_q == StGrantI);
    grant_d   = (state_q == StGrantD);
    if (state_q == StGrantI) begin
      mem_addr  = i_addr;
      mem_wr    = i_wr;
      mem_rw    = i_rw;
      mem_valid = i_valid;
      i_ready   = mem_ready;
      i_rd      = mem_ready ? mem_rd : '0;
    end else if (state_q == StGrantD) begin
      mem_addr  = d_addr;
      mem_wr    = d_wr;
      mem_rw    = d_rw;
      mem_valid = d_valid;
      d_ready   = mem_ready;
      d_rd      = mem_ready ? mem_rd : '0;
    end
  end

  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for reset/contention plus
// hand sequences for single read, abandon, timeout and fixed priority.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned BS = 256;

  localparam logic [AW-1:0] IAddr = 28'h0000100;
  localparam logic [AW-1:0] DAddr = 28'h0000200;
  localparam logic [BS-1:0] MemRd = {8{32'hA5A5_0001}};
  localparam logic [BS-1:0] IWr   = {8{32'h1111_2222}};
  localparam logic [BS-1:0] DWr   = {8{32'h3333_4444}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [AW-1:0] i_addr = IAddr, d_addr = DAddr;
  logic [BS-1:0] i_wr = IWr, d_wr = DWr, mem_rd = MemRd;
  logic          i_rw = 1'b0, d_rw = 1'b1;
  logic          i_valid = 1'b0, d_valid = 1'b0, mem_ready = 1'b0;

  logic [BS-1:0] i_rd0, d_rd0, mem_wr0, i_rd1, d_rd1, mem_wr1;
  logic [AW-1:0] mem_addr0, mem_addr1;
  logic i_ready0, d_ready0, mem_rw0, mem_valid0, grant_i0, grant_d0, err0;
  logic i_ready1, d_ready1, mem_rw1, mem_valid1, grant_i1, grant_d1, err1;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT(15), .FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_wr(i_wr), .i_rw(i_rw), .i_valid(i_valid), .i_rd(i_rd0),
    .i_ready(i_ready0),
    .d_addr(d_addr), .d_wr(d_wr), .d_rw(d_rw), .d_valid(d_valid), .d_rd(d_rd0),
    .d_ready(d_ready0),
    .mem_addr(mem_addr0), .mem_wr(mem_wr0), .mem_rw(mem_rw0), .mem_valid(mem_valid0),
    .mem_rd(mem_rd), .mem_ready(mem_ready),
    .grant_i(grant_i0), .grant_d(grant_d0), .err_timeout(err0)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT(15), .FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_wr(i_wr), .i_rw(i_rw), .i_valid(i_valid), .i_rd(i_rd1),
    .i_ready(i_ready1),
    .d_addr(d_addr), .d_wr(d_wr), .d_rw(d_rw), .d_valid(d_valid), .d_rd(d_rd1),
    .d_ready(d_ready1),
    .mem_addr(mem_addr1), .mem_wr(mem_wr1), .mem_rw(mem_rw1), .mem_valid(mem_valid1),
    .mem_rd(mem_rd), .mem_ready(mem_ready),
    .grant_i(grant_i1), .grant_d(grant_d1), .err_timeout(err1)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic       dv;
    logic       mr;
    logic [1:0] eg;   // {grant_d, grant_i}
    logic       emv;
    logic       eir;
    logic       edr;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, iv, dv, mr, input logic [1:0] eg,
                     input logic emv, eir, edr, eerr);
    vec_t v;
    v = '{rst: r, iv: iv, dv: dv, mr: mr, eg: eg, emv: emv, eir: eir, edr: edr, eerr: eerr};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, iv, dv, mr);
    @(negedge clk);
    rst       = r;
    i_valid   = iv;
    d_valid   = dv;
    mem_ready = mr;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ea;
    logic [BS-1:0] ew;

    // Reset held two cycles with both valids high, then four contended transfers.
    add(1, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      logic [1:0] g;
      g = (t % 2 == 0) ? 2'b10 : 2'b01;
      add(0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
      add(0, 1, 1, 0, g, 1, 0, 0, 0);
      add(0, 1, 1, 0, g, 1, 0, 0, 0);
      add(0, 1, 1, 1, g, 1, g[0], g[1], 0);
    end
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);  // mem_ready in idle is ignored
    add(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    drive(1, 0, 0, 0);
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].iv, vecs[k].dv, vecs[k].mr);
      ea = (vecs[k].eg == 2'b01) ? IAddr : (vecs[k].eg == 2'b10) ? DAddr : '0;
      ew = (vecs[k].eg == 2'b01) ? IWr : (vecs[k].eg == 2'b10) ? DWr : '0;
      chk($sformatf("tbl%0d grant", k), BS'({grant_d0, grant_i0}), BS'(vecs[k].eg));
      chk($sformatf("tbl%0d mem_valid", k), BS'(mem_valid0), BS'(vecs[k].emv));
      chk($sformatf("tbl%0d i_ready", k), BS'(i_ready0), BS'(vecs[k].eir));
      chk($sformatf("tbl%0d d_ready", k), BS'(d_ready0), BS'(vecs[k].edr));
      chk($sformatf("tbl%0d err", k), BS'(err0), BS'(vecs[k].eerr));
      chk($sformatf("tbl%0d mem_addr", k), BS'(mem_addr0), BS'(ea));
      chk($sformatf("tbl%0d mem_wr", k), mem_wr0, ew);
      chk($sformatf("tbl%0d mem_rw", k), BS'(mem_rw0), BS'(vecs[k].eg == 2'b10));
      chk($sformatf("tbl%0d i_rd", k), i_rd0, vecs[k].eir ? MemRd : '0);
      chk($sformatf("tbl%0d d_rd", k), d_rd0, vecs[k].edr ? MemRd : '0);
    end

    // Single I read, ready three cycles after mem_valid.
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk("rd idle mem_valid", BS'(mem_valid0), BS'(0));
    drive(0, 1, 0, 0);
    chk("rd mem_valid", BS'(mem_valid0), BS'(1));
    chk("rd mem_addr", BS'(mem_addr0), BS'(IAddr));
    chk("rd mem_rw", BS'(mem_rw0), BS'(0));
    chk("rd i_rd before ready", i_rd0, '0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 1);
    chk("rd i_ready", BS'(i_ready0), BS'(1));
    chk("rd i_rd", i_rd0, MemRd);
    chk("rd d_ready", BS'(d_ready0), BS'(0));
    chk("rd d_rd", d_rd0, '0);
    drive(0, 0, 0, 0);
    chk("rd after mem_valid", BS'(mem_valid0), BS'(0));
    chk("rd after i_ready", BS'(i_ready0), BS'(0));

    // Abandon: I drops valid after two grant cycles.
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("ab grant_i", BS'(grant_i0), BS'(1));
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("ab drop mem_valid", BS'(mem_valid0), BS'(0));
    chk("ab drop i_ready", BS'(i_ready0), BS'(0));
    drive(0, 0, 0, 0);
    chk("ab idle grant_i", BS'(grant_i0), BS'(0));
    chk("ab err", BS'(err0), BS'(0));

    // Timeout: D granted, no mem_ready for 16 grant cycles.
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    for (int c = 0; c < 16; c++) begin
      drive(0, 0, 1, 0);
      chk($sformatf("to cyc%0d grant_d", c), BS'(grant_d0), BS'(1));
      chk($sformatf("to cyc%0d err", c), BS'(err0), BS'(0));
    end
    drive(0, 0, 0, 0);
    chk("to idle grant_d", BS'(grant_d0), BS'(0));
    chk("to err set", BS'(err0), BS'(1));
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 1);
    chk("to later d_ready", BS'(d_ready0), BS'(1));
    chk("to err sticky", BS'(err0), BS'(1));
    drive(0, 0, 0, 0);
    chk("to err sticky idle", BS'(err0), BS'(1));
    drive(1, 1, 1, 0);
    drive(0, 1, 1, 0);
    chk("to err cleared", BS'(err0), BS'(0));
    chk("to reset grant", BS'({grant_d0, grant_i0}), BS'(0));
    drive(0, 1, 1, 0);
    chk("to tie after reset", BS'({grant_d0, grant_i0}), BS'(2'b10));

    // Mid-transaction reset drops the grant.
    drive(1, 1, 1, 0);
    drive(0, 0, 0, 0);
    chk("midrst grant", BS'({grant_d0, grant_i0}), BS'(0));
    chk("midrst mem_valid", BS'(mem_valid0), BS'(0));

    // Fixed priority (dut1): D wins every tie until its valid drops.
    drive(1, 1, 1, 0);
    for (int t = 0; t < 3; t++) begin
      drive(0, 1, 1, 0);
      chk($sformatf("fp%0d idle grant", t), BS'({grant_d1, grant_i1}), BS'(0));
      drive(0, 1, 1, 1);
      chk($sformatf("fp%0d grant", t), BS'({grant_d1, grant_i1}), BS'(2'b10));
      chk($sformatf("fp%0d d_ready", t), BS'(d_ready1), BS'(1));
      chk($sformatf("fp%0d d_rd", t), d_rd1, MemRd);
    end
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    chk("fp I served", BS'({grant_d1, grant_i1}), BS'(2'b01));
    chk("fp I mem_addr", BS'(mem_addr1), BS'(IAddr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256-bit DDR/memory port between the instruction-cache controller (requester I) and the data-cache controller (requester D).
- Each requester drives a block request (addr/wr/rw/valid) and holds valid until it sees its ready.
- The arbiter registers a grant, forwards the granted request to memory, and routes mem_ready and read data back only to the granted side.
- It sits between both cache controllers and the DDR model/controller.

Parameters:
- ADDR_WIDTH, 28, block address width (same format as cache mem_addr, offset bits zero).
- BLOCK_SIZE, 256, data width of one memory transfer in bits.
- TIMEOUT, 1023, max cycles a grant may wait for mem_ready before abort; must be < 2^10.
- FIXED_PRIO, 0, 0 = round-robin; 1 = D always wins ties.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_addr  in  ADDR_WIDTH  requester I block address
- i_wr  in  BLOCK_SIZE  requester I write data
- i_rw  in  1  requester I: 1 = write, 0 = read
- i_valid  in  1  requester I request
- i_rd  out  BLOCK_SIZE  read data to I
- i_ready  out  1  completion to I
- d_addr, d_wr, d_rw, d_valid, d_rd, d_ready: same directions, widths and meanings as the I group, for requester D
- mem_addr  out  ADDR_WIDTH  to memory
- mem_wr  out  BLOCK_SIZE  to memory
- mem_rw  out  1  to memory
- mem_valid  out  1  to memory
- mem_rd  in  BLOCK_SIZE  from memory
- mem_ready  in  1  from memory; one-cycle completion pulse
- grant_i  out  1  status: state == GRANT_I
- grant_d  out  1  status: state == GRANT_D
- err_timeout  out  1  sticky timeout flag

Behaviour:
- States: IDLE, GRANT_I, GRANT_D. Registered state; last_grant register (I or D); 10-bit wait counter.
- Reset (rst high at a clk edge), applies mid-transaction too:
  - state = IDLE, last_grant = I, counter = 0, err_timeout = 0.
  - All combinational outputs then read 0: mem_*, i_/d_ready, i_/d_rd, grant_*.
- IDLE arbitration:
  - Only I valid -> GRANT_I. Only D valid -> GRANT_D. Neither -> stay in IDLE.
  - Both valid, FIXED_PRIO = 0: grant the side that is not last_grant. After reset the first tie goes to D.
  - Both valid, FIXED_PRIO = 1: grant D.
  - Counter cleared on entering any GRANT state.
- GRANT_x outputs, all combinational:
  - mem_addr/mem_wr/mem_rw = x's signals.
  - mem_valid = x_valid.
  - x_ready = mem_ready.
  - x_rd = mem_rd when mem_ready, else 0.
  - The non-granted side sees ready = 0 and rd = 0.
- GRANT_x transitions:
  - mem_ready = 1 -> IDLE next cycle; last_grant <= x.
  - x_valid = 0 (requester abandoned) -> IDLE; last_grant <= x; no ready issued.
  - counter == TIMEOUT without mem_ready -> IDLE; err_timeout <= 1; last_grant <= x.
  - Otherwise counter increments; it saturates and never wraps.
- Dead cycle: outside GRANT states mem_valid = 0. There is always at least one idle cycle on the memory port between transfers.
  - Grant latency: valid seen in IDLE at cycle N -> mem_valid at N+1.
  - Back-to-back: ready at M -> next mem_valid at M+2 at the earliest.
  - This guarantees a requester's stale valid in the ready cycle is never re-granted.
- A requester that keeps valid high after its ready (D going write-back -> allocate) is treated as a new request and arbitrated normally against I.
- A simultaneous mem_ready and x_valid drop in the same cycle counts as completion: x_ready pulses and last_grant is updated.
- err_timeout is cleared only by rst.
- mem_ready seen in IDLE is ignored: no ready to either side, no state change.

Decomposition:
- Shared cpu_mem package holds:
  - state encodings (IDLE = 2'b00, GRANT_I = 2'b01, GRANT_D = 2'b10);
  - ADDR_WIDTH/BLOCK_SIZE defaults;
  - requester index constants.
- One natural sub-module, rr_pick2: 2-way round-robin/fixed-priority selector (inputs: two valids, last_grant, mode; output: winner, any). It is combinational and reused by a future IO-bus arbiter.
- The FSM, counter and output muxes stay in the top module.

Test Plan:
- Reset: rst high 2 cycles while both valids are high -> grant_* = 0, mem_valid = 0, err_timeout = 0; after release, D is granted first and mem_valid rises the next cycle.
- Single I read: i_addr = 28'h0000100, i_rw = 0; memory returns mem_rd = {8{32'hA5A5_0001}} with ready 3 cycles after mem_valid -> i_ready is a one-cycle pulse with i_rd = that value, d_ready stays 0, and mem_valid is low the next cycle.
- Contention: both hold valid for 4 transfers (mem_ready 2 cycles after each grant) -> grant order D, I, D, I; one dead cycle between transfers.
- FIXED_PRIO = 1, both valid continuously -> D wins every arbitration; I is served only once D's valid drops.
- Abandon: grant I, drop i_valid after 2 cycles with no mem_ready -> IDLE next cycle, no i_ready, err_timeout = 0.
- Timeout: TIMEOUT = 15, grant D, mem_ready never asserted -> IDLE after 16 grant cycles, err_timeout = 1 and sticky through later successful transfers until rst.
